p_history_reg: RTL

//  Parametrised shift history of the last DEPTH samples, each WIDTH bits wide.

---
 rtl/p_hist_pkg.sv | 21 ++
 rtl/p_history_reg_if.sv | 59 +++++
 rtl/p_hist_stage.sv | 34 +++
 rtl/p_history_reg.sv | 119 +++++++++++
 4 files changed

// File: rtl/p_hist_pkg.sv
// ---------------------------------------------------------------------------
// p_hist_pkg
// Shared constants, types and helpers for the health-monitor sample history.
//   P_DIGIT_W    : default width of one stored digit
//   P_HIST_DEPTH : default number of history stages
//   digit_t      : one digit sample
//   is_pow2()    : true when the argument is a positive power of two
// ---------------------------------------------------------------------------
package p_hist_pkg;

   localparam int P_DIGIT_W    = 4;
   localparam int P_HIST_DEPTH = 8;

   typedef logic [P_DIGIT_W-1:0] digit_t;

   // The averager divides by shifting, so it only works for power-of-two depths
   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/p_history_reg_if.sv
// ---------------------------------------------------------------------------
// p_history_reg_if
// Bus between the history register and its user (display/compare logic).
//   i_shift_en : capture i_din into stage 0 and age every stage
//   i_din      : sample to capture
//   i_rd_idx   : stage to read back (0 = newest)
//   o_rd_data  : registered readout of stage i_rd_idx
//   o_newest   : stage 0 contents
//   o_count    : number of valid entries, 0..DEPTH
//   o_full     : o_count == DEPTH
//   o_sum      : sum of the valid stages
//   o_avg      : o_sum >> log2(DEPTH)   (only with P_HIST_AVG_EN)
//   o_avg_valid: history filled at least once (only with P_HIST_AVG_EN)
// Macro: P_HIST_AVG_EN adds the averager signals.
// ---------------------------------------------------------------------------
interface p_history_reg_if
   import p_hist_pkg::*;
#(
   parameter int WIDTH = P_DIGIT_W,
   parameter int DEPTH = P_HIST_DEPTH
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int SUM_W = WIDTH + $clog2(DEPTH + 1);

   logic             i_shift_en;
   logic [WIDTH-1:0] i_din;
   logic [IDX_W-1:0] i_rd_idx;
   logic [WIDTH-1:0] o_rd_data;
   logic [WIDTH-1:0] o_newest;
   logic [IDX_W:0]   o_count;
   logic             o_full;
   logic [SUM_W-1:0] o_sum;
`ifdef P_HIST_AVG_EN
   logic [WIDTH-1:0] o_avg;
   logic             o_avg_valid;
`endif

`ifdef P_HIST_AVG_EN
   modport master (
      output i_shift_en, i_din, i_rd_idx,
      input  o_rd_data, o_newest, o_count, o_full, o_sum, o_avg, o_avg_valid
   );
   modport slave (
      input  i_shift_en, i_din, i_rd_idx,
      output o_rd_data, o_newest, o_count, o_full, o_sum, o_avg, o_avg_valid
   );
`else
   modport master (
      output i_shift_en, i_din, i_rd_idx,
      input  o_rd_data, o_newest, o_count, o_full, o_sum
   );
   modport slave (
      input  i_shift_en, i_din, i_rd_idx,
      output o_rd_data, o_newest, o_count, o_full, o_sum
   );
`endif

endinterface

// File: rtl/p_hist_stage.sv
// ---------------------------------------------------------------------------
// p_hist_stage
// One WIDTH-bit history stage: synchronous reset wins over load.
//   clk    : clock
//   rst    : synchronous, active-high reset
//   i_load : capture i_d
//   i_d    : next value
//   o_q    : stored value
// ---------------------------------------------------------------------------
module p_hist_stage
   import p_hist_pkg::*;
#(
   parameter int WIDTH = P_DIGIT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Reset clears the stage even when a load is requested in the same cycle
   always_ff @(posedge clk) begin
      if (rst)
         r_q <= '0;
      else if (i_load)
         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/p_history_reg.sv
// ---------------------------------------------------------------------------
// p_history_reg
// Shift history of the last DEPTH samples with valid count, running sum and
// registered indexed readout.
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : p_history_reg_if.slave (shift/din/rd_idx in; rd_data, newest,
//         count, full, sum and optional avg/avg_valid out)
// Macro: P_HIST_AVG_EN adds a registered average (DEPTH must be a power of 2).
// ---------------------------------------------------------------------------
module p_history_reg
   import p_hist_pkg::*;
#(
   parameter int WIDTH = P_DIGIT_W,
   parameter int DEPTH = P_HIST_DEPTH
) (
   input logic           clk,
   input logic           rst,
   p_history_reg_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int SUM_W = WIDTH + $clog2(DEPTH + 1);
   localparam int RD_N  = 1 << IDX_W;
   localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

   logic [WIDTH-1:0] w_stage  [DEPTH];
   logic [WIDTH-1:0] w_rd_arr [RD_N];
   logic             w_full;
   logic [IDX_W:0]   w_next_count;
   logic [WIDTH-1:0] w_drop;
   logic [SUM_W-1:0] w_next_sum;

   logic [IDX_W:0]   r_count;
   logic [SUM_W-1:0] r_sum;
   logic [WIDTH-1:0] r_rd_data;

   // Stage chain: stage 0 takes the new sample, every other stage its neighbour
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         p_hist_stage #(.WIDTH(WIDTH)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_load (bus.i_shift_en),
            .i_d    (bus.i_din),
            .o_q    (w_stage[i])
         );
      end else begin : g_tail
         p_hist_stage #(.WIDTH(WIDTH)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_load (bus.i_shift_en),
            .i_d    (w_stage[i-1]),
            .o_q    (w_stage[i])
         );
      end
   end

   // Readout table padded to a power of two so indices past DEPTH read zero
   for (genvar j = 0; j < RD_N; j++) begin : g_rd
      if (j < DEPTH) begin : g_real
         assign w_rd_arr[j] = w_stage[j];
      end else begin : g_pad
         assign w_rd_arr[j] = '0;
      end
   end

   // Once full, the oldest sample falls off the end and leaves the sum
   assign w_full       = (r_count == DEPTH_C);
   assign w_next_count = w_full ? r_count : r_count + 1'b1;
   assign w_drop       = w_full ? w_stage[DEPTH-1] : '0;
   assign w_next_sum   = r_sum + SUM_W'(bus.i_din) - SUM_W'(w_drop);

   // Count and sum move with each shift; readout samples pre-shift contents
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count   <= '0;
         r_sum     <= '0;
         r_rd_data <= '0;
      end else begin
         r_rd_data <= w_rd_arr[bus.i_rd_idx];
         if (bus.i_shift_en) begin
            r_count <= w_next_count;
            r_sum   <= w_next_sum;
         end
      end
   end

   assign bus.o_rd_data = r_rd_data;
   assign bus.o_newest  = w_stage[0];
   assign bus.o_count   = r_count;
   assign bus.o_full    = w_full;
   assign bus.o_sum     = r_sum;

`ifdef P_HIST_AVG_EN
   logic [WIDTH-1:0] r_avg;
   logic             r_avg_valid;

   if (!is_pow2(DEPTH)) begin : g_depth_check
      $error("p_history_reg: DEPTH must be a power of 2 when the averager is enabled");
   end

   // Division by DEPTH is a shift by IDX_W; avg_valid latches once history fills
   always_ff @(posedge clk) begin
      if (rst) begin
         r_avg       <= '0;
         r_avg_valid <= 1'b0;
      end else if (bus.i_shift_en) begin
         r_avg <= WIDTH'(w_next_sum >> IDX_W);
         if (w_next_count == DEPTH_C)
            r_avg_valid <= 1'b1;
      end
   end

   assign bus.o_avg       = r_avg;
   assign bus.o_avg_valid = r_avg_valid;
`endif

endmodule
